// File: rtl/map_frame_scheduler_if.sv
// Event, map-operation and classifier handshakes between the frame scheduler and its neighbours.
// master = scheduler side; slave = event decoder / map datapath / classifier side.
interface map_frame_scheduler_if #(
  parameter int ADDR_W = 10
);
  logic              evt_valid;
  logic [ADDR_W-1:0] evt_addr;
  logic              evt_ready;
  logic              map_op_valid;
  logic              map_op_kind;
  logic [ADDR_W-1:0] map_op_addr;
  logic              map_op_ready;
  logic              cls_start;
  logic              cls_done;

  modport master (
    input  evt_valid, evt_addr, map_op_ready, cls_done,
    output evt_ready, map_op_valid, map_op_kind, map_op_addr, cls_start
  );

  modport slave (
    output evt_valid, evt_addr, map_op_ready, cls_done,
    input  evt_ready, map_op_valid, map_op_kind, map_op_addr, cls_start
  );
endinterface

// File: rtl/map_frame_scheduler.sv
// Gradient-map RMW port owner: event increments, per-frame decay sweep, classifier kick; op valid 1 cycle after event accept.
// Events are backpressured via evt_ready (never dropped); ops held stable until map_op_ready.
module map_frame_scheduler #(
  parameter int CLK_FREQ_HZ     = 12_000_000,
  parameter int FRAME_PERIOD_MS = 50,
  parameter int MAP_DEPTH       = 1024,
  parameter int CLS_TIMEOUT     = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  map_frame_scheduler_if.master       bus,
  output logic                        frame_tick,
  output logic                        busy,
  output logic [15:0]                 frame_count,
  output logic [7:0]                  overrun_count,
  output logic [7:0]                  timeout_count
);
  localparam int FRAME_CYCLES = CLK_FREQ_HZ / 1000 * FRAME_PERIOD_MS;
  localparam int ADDR_W       = $clog2(MAP_DEPTH);
  localparam int TMR_W        = $clog2(FRAME_CYCLES);
  localparam int TO_W         = $clog2(CLS_TIMEOUT + 1);

  typedef enum logic [1:0] {ACCUM, DECAY, CLASSIFY} state_t;

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  tmr;
  logic              tick_pend;
  logic              op_valid;
  logic              op_kind;
  logic [ADDR_W-1:0] op_addr;
  logic [ADDR_W-1:0] sweep_addr;
  logic              cls_start_q;
  logic              busy_q;
  logic [TO_W-1:0]   to_cnt;
  logic              done_seen;

  logic op_free, evt_ready, evt_acc, last_sweep, cls_finish, cls_tmo;
  logic go_decay, go_cls, leave_cls;

  assign frame_tick = (tmr == TMR_W'(FRAME_CYCLES - 1));
  assign op_free    = !op_valid || bus.map_op_ready;
  assign evt_acc    = bus.evt_valid && evt_ready;
  assign last_sweep = (sweep_addr == ADDR_W'(MAP_DEPTH - 1));
  assign cls_finish = bus.cls_done || done_seen;
  assign cls_tmo    = (to_cnt == TO_W'(CLS_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    evt_ready = 1'b0;
    go_decay  = 1'b0;
    go_cls    = 1'b0;
    leave_cls = 1'b0;
    case (state)
      ACCUM: begin
        evt_ready = !tick_pend && op_free;
        if (tick_pend && op_free) begin
          state_nxt = DECAY;
          go_decay  = 1'b1;
        end
      end
      DECAY: begin
        if (bus.map_op_ready && last_sweep) begin
          state_nxt = CLASSIFY;
          go_cls    = 1'b1;
        end
      end
      CLASSIFY: begin
        evt_ready = op_free;
        // A finished/expired classification still waits for any in-flight op
        if ((cls_finish || cls_tmo) && op_free) begin
          state_nxt = ACCUM;
          leave_cls = 1'b1;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ACCUM;
      tmr           <= '0;
      tick_pend     <= 1'b0;
      op_valid      <= 1'b0;
      op_kind       <= 1'b0;
      op_addr       <= '0;
      sweep_addr    <= '0;
      cls_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      to_cnt        <= '0;
      done_seen     <= 1'b0;
      frame_count   <= '0;
      overrun_count <= '0;
      timeout_count <= '0;
    end else begin
      state       <= state_nxt;
      tmr         <= frame_tick ? '0 : tmr + TMR_W'(1);
      busy_q      <= (state_nxt != ACCUM);
      cls_start_q <= go_cls;

      if (go_decay)
        tick_pend <= 1'b0;
      else if (frame_tick && state == ACCUM)
        tick_pend <= 1'b1;

      // Ticks outside ACCUM, or on top of one already pending, are lost
      if (frame_tick && (state != ACCUM || tick_pend) && overrun_count != 8'hFF)
        overrun_count <= overrun_count + 8'd1;

      if (go_decay) begin
        op_valid    <= 1'b1;
        op_kind     <= 1'b1;
        op_addr     <= '0;
        sweep_addr  <= '0;
        frame_count <= frame_count + 16'd1;
      end else if (state == DECAY) begin
        if (bus.map_op_ready) begin
          if (last_sweep) begin
            op_valid <= 1'b0;
          end else begin
            sweep_addr <= sweep_addr + ADDR_W'(1);
            op_addr    <= sweep_addr + ADDR_W'(1);
          end
        end
      end else if (evt_acc) begin
        op_valid <= 1'b1;
        op_kind  <= 1'b0;
        op_addr  <= bus.evt_addr;
      end else if (bus.map_op_ready) begin
        op_valid <= 1'b0;
      end

      if (go_cls) begin
        to_cnt    <= '0;
        done_seen <= 1'b0;
      end else if (state == CLASSIFY) begin
        if (!cls_tmo)
          to_cnt <= to_cnt + TO_W'(1);
        if (bus.cls_done)
          done_seen <= 1'b1;
      end

      if (leave_cls && !cls_finish && timeout_count != 8'hFF)
        timeout_count <= timeout_count + 8'd1;
    end
  end

  assign bus.evt_ready    = evt_ready;
  assign bus.map_op_valid = op_valid;
  assign bus.map_op_kind  = op_kind;
  assign bus.map_op_addr  = op_addr;
  assign bus.cls_start    = cls_start_q;
  assign busy             = busy_q;
endmodule

// File: tb/tb_map_frame_scheduler.sv
// Directed bench for map_frame_scheduler: FRAME_CYCLES=100, MAP_DEPTH=16, CLS_TIMEOUT=20.
// Expected map ops are queued at stimulus time and matched by a separate negedge monitor.
module tb_map_frame_scheduler;
  typedef struct packed {
    logic       kind;
    logic [3:0] addr;
  } op_t;

  logic        clk;
  logic        rst;
  logic        frame_tick;
  logic        busy;
  logic [15:0] frame_count;
  logic [7:0]  overrun_count;
  logic [7:0]  timeout_count;

  map_frame_scheduler_if #(.ADDR_W(4)) bus();

  map_frame_scheduler #(
    .CLK_FREQ_HZ(100_000),
    .FRAME_PERIOD_MS(1),
    .MAP_DEPTH(16),
    .CLS_TIMEOUT(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .frame_tick(frame_tick),
    .busy(busy),
    .frame_count(frame_count),
    .overrun_count(overrun_count),
    .timeout_count(timeout_count)
  );

  int  n_cmp = 0;
  int  n_bad = 0;
  int  n_cls = 0;
  int  cyc   = 0;
  op_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  // Land on the negedge of cycle c (outputs of cycle c are stable)
  task automatic chk_at(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  // Land just after the posedge that starts cycle c, ready to drive inputs
  task automatic drv_at(input int c);
    do begin @(posedge clk); #1; end while (cyc < c);
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 16; i++) begin
      op_t o;
      o.kind = 1'b1;
      o.addr = 4'(i);
      exp_q.push_back(o);
    end
  endtask

  task automatic send(input logic [3:0] a, output int waits);
    bit  acc;
    op_t o;
    acc = 0;
    waits = 0;
    bus.evt_valid = 1'b1;
    bus.evt_addr  = a;
    while (!acc && waits <= 50) begin
      @(negedge clk);
      if (bus.evt_ready) begin
        acc = 1;
        o.kind = 1'b0;
        o.addr = a;
        exp_q.push_back(o);
      end else begin
        waits++;
        @(posedge clk); #1;
      end
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL evt_accept_timeout: addr %0h not accepted within %0d cycles", a, waits);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: scoreboard match on every handshake, hold-stability on every stall
  initial begin
    bit  prev_stall;
    op_t prev_op, cur, e;
    prev_stall = 0;
    prev_op = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        cur.kind = bus.map_op_kind;
        cur.addr = bus.map_op_addr;
        if (prev_stall) chk("op_stable", 32'(cur), 32'(prev_op));
        if (bus.map_op_valid && bus.map_op_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL op_unexpected @cyc %0d: got kind %0d addr %0h, none queued", cyc, cur.kind, cur.addr);
          end else begin
            e = exp_q.pop_front();
            chk("op_match", 32'(cur), 32'(e));
          end
        end
        if (bus.cls_start) n_cls++;
        prev_stall = bus.map_op_valid && !bus.map_op_ready;
        prev_op = cur;
      end
    end
  end

  initial begin
    int w;
    rst = 1'b1;
    bus.evt_valid    = 1'b0;
    bus.evt_addr     = '0;
    bus.map_op_ready = 1'b1;
    bus.cls_done     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    chk_at(0);
    chk("rst_evt_ready", bus.evt_ready, 1);
    chk("rst_op_valid", bus.map_op_valid, 0);
    chk("rst_op_kind", bus.map_op_kind, 0);
    chk("rst_op_addr", bus.map_op_addr, 0);
    chk("rst_cls_start", bus.cls_start, 0);
    chk("rst_frame_tick", frame_tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_overrun", overrun_count, 0);
    chk("rst_timeout", timeout_count, 0);

    // Back-to-back events
    drv_at(2);
    send(4'd5, w); chk("stream_wait0", w, 0);
    send(4'd6, w); chk("stream_wait1", w, 0);
    send(4'd7, w); chk("stream_wait2", w, 0);
    bus.evt_valid = 1'b0;
    chk_at(5); chk("stream_last_valid", bus.map_op_valid, 1);
    chk_at(6); chk("stream_idle_valid", bus.map_op_valid, 0);

    // Backpressure: op 9 stalled four cycles, event 10 waits behind it
    drv_at(10);
    bus.map_op_ready = 1'b0;
    send(4'd9, w);
    bus.evt_addr = 4'd10;
    for (int k = 11; k <= 14; k++) begin
      chk_at(k);
      chk("bp_evt_ready", bus.evt_ready, 0);
      chk("bp_op_valid", bus.map_op_valid, 1);
      chk("bp_op_addr", bus.map_op_addr, 9);
    end
    drv_at(15);
    bus.map_op_ready = 1'b1;
    chk_at(15);
    chk("bp_release_ready", bus.evt_ready, 1);
    exp_q.push_back('{kind: 1'b0, addr: 4'd10});
    drv_at(16);
    bus.evt_valid = 1'b0;

    // First frame: tick, sweep, classifier answers 3 cycles after start
    chk_at(98);  chk("tick_early", frame_tick, 0);
    chk_at(99);  chk("tick_first", frame_tick, 1);
    push_sweep();
    chk_at(100);
    chk("tick_once", frame_tick, 0);
    chk("tick_pend_blocks", bus.evt_ready, 0);
    chk("pre_decay_busy", busy, 0);
    chk_at(101);
    chk("decay_busy", busy, 1);
    chk("decay_frame_count", frame_count, 1);
    chk("decay_evt_ready", bus.evt_ready, 0);
    chk_at(116); chk("cls_start_early", bus.cls_start, 0);
    chk_at(117);
    chk("cls_start_pulse", bus.cls_start, 1);
    chk("sweep_done_valid", bus.map_op_valid, 0);
    chk_at(118); chk("cls_start_once", bus.cls_start, 0);
    drv_at(120); bus.cls_done = 1'b1;
    chk_at(120); chk("cls_wait_busy", busy, 1);
    drv_at(121); bus.cls_done = 1'b0;
    chk_at(121);
    chk("cls_done_busy", busy, 0);
    chk("cls_done_evt_ready", bus.evt_ready, 1);
    chk("cls_done_timeout", timeout_count, 0);

    // Tick lands while an event op is stalled
    drv_at(198);
    bus.map_op_ready = 1'b0;
    send(4'd3, w);
    bus.evt_addr = 4'd12;
    for (int k = 199; k <= 219; k++) begin
      if (k == 203) begin
        drv_at(203);
        bus.map_op_ready = 1'b1;
      end
      chk_at(k);
      if (k == 199) chk("stall_tick", frame_tick, 1);
      chk("stall_evt_blocked", bus.evt_ready, 0);
      chk("stall_busy", busy, (k >= 204) ? 1 : 0);
      if (k == 203) push_sweep();
    end
    chk_at(220);
    chk("stall_cls_start", bus.cls_start, 1);
    chk("cls_evt_ready", bus.evt_ready, 1);
    chk("stall_frame_count", frame_count, 2);
    exp_q.push_back('{kind: 1'b0, addr: 4'd12});
    drv_at(221);
    bus.evt_valid = 1'b0;

    // Classifier never answers: back to ACCUM 20 cycles after cls_start
    chk_at(239);
    chk("tmo_early_busy", busy, 1);
    chk("tmo_early_count", timeout_count, 0);
    chk_at(240);
    chk("tmo_busy", busy, 0);
    chk("tmo_count", timeout_count, 1);

    // Overrun: sweep stalled across the next tick
    chk_at(299); chk("ovr_tick3", frame_tick, 1);
    push_sweep();
    drv_at(301); bus.map_op_ready = 1'b0;
    chk_at(301);
    chk("ovr_busy", busy, 1);
    chk("ovr_frame_count_a", frame_count, 3);
    chk_at(399);
    chk("ovr_tick4", frame_tick, 1);
    chk("ovr_before", overrun_count, 0);
    chk_at(400);
    chk("ovr_count", overrun_count, 1);
    chk("ovr_frame_count_b", frame_count, 3);
    chk("ovr_op_addr", bus.map_op_addr, 0);
    drv_at(402); bus.map_op_ready = 1'b1;
    chk_at(418); chk("ovr_cls_start", bus.cls_start, 1);
    chk_at(438);
    chk("ovr_back_busy", busy, 0);
    chk("ovr_timeout2", timeout_count, 2);
    chk("ovr_frame_count_c", frame_count, 3);
    chk_at(450);
    chk("ovr_no_extra_sweep", bus.map_op_valid, 0);
    chk("ovr_idle_busy", busy, 0);
    chk_at(499);
    push_sweep();
    chk_at(501);
    chk("next_frame_count", frame_count, 4);
    chk("next_busy", busy, 1);
    chk_at(517); chk("next_cls_start", bus.cls_start, 1);
    drv_at(518); bus.cls_done = 1'b1;
    drv_at(519); bus.cls_done = 1'b0;
    chk_at(520);
    chk("end_busy", busy, 0);
    chk("end_timeout", timeout_count, 2);
    chk("end_overrun", overrun_count, 1);
    chk("end_cls_pulses", n_cls, 4);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/map_frame_scheduler.md
# map_frame_scheduler

Frame-level controller for the gradient-map datapath inside the gesture core. Owns the single read-modify-write port of the map: it arbitrates between event-increment requests from the event decoder (UART or parallel EVT2 front end) and its own per-frame decay sweep. After each sweep it starts the classifier and waits for its result. The frame tick is generated internally from `CLK_FREQ_HZ` and `FRAME_PERIOD_MS`.

## Interface
- `CLK_FREQ_HZ`, 12_000_000: clock frequency.
- `FRAME_PERIOD_MS`, 50: frame period. Frame length is `FRAME_CYCLES = CLK_FREQ_HZ/1000*FRAME_PERIOD_MS`, computed as a localparam, must be ≥ 2.
- `MAP_DEPTH`, 1024: number of map cells. `ADDR_W = $clog2(MAP_DEPTH)`.
- `CLS_TIMEOUT`, 4096: maximum cycles to wait for `cls_done`.
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous and active-high.
- `evt_valid` in 1: event increment request.
- `evt_addr` in ADDR_W: cell index of the event.
- `evt_ready` out 1: event accepted on `evt_valid && evt_ready`.
- `map_op_valid` out 1: a map operation is presented to the datapath.
- `map_op_kind` out 1: 0 = event increment, 1 = decay.
- `map_op_addr` out ADDR_W: cell address of the operation.
- `map_op_ready` in 1: datapath accepts the operation.
- `cls_start` out 1: one-cycle pulse that starts classification.
- `cls_done` in 1: classifier has finished.
- `frame_tick` out 1: one-cycle pulse at the end of each frame period.
- `busy` out 1: high in DECAY or CLASSIFY.
- `frame_count` out 16: count of decay sweeps started; wraps.
- `overrun_count` out 8: count of frame ticks dropped; saturates at 255.
- `timeout_count` out 8: count of classifier timeouts; saturates at 255.

## Operation
- **Frame timer:** free-running counter over 0..FRAME_CYCLES-1. `frame_tick` pulses when the counter wraps. The timer runs in every state.
- **ACCUM state:**
  - `evt_ready = !tick_pend && (!map_op_valid || map_op_ready)`.
  - On event accept: next cycle `map_op_valid=1`, `map_op_kind=0`, `map_op_addr=evt_addr`.
  - The op is held stable until `map_op_ready`.
- **Tick during ACCUM:** sets `tick_pend`. Once no op is pending, or the pending op completes this cycle, transition to DECAY. On the transition: clear `tick_pend`, `sweep_addr=0`, `frame_count+1`.
- **DECAY state:**
  - `evt_ready=0`.
  - Presents `kind=1` at `sweep_addr` and advances the address on each handshake.
  - Handshake at `MAP_DEPTH-1`: `map_op_valid` drops and the state moves to CLASSIFY.
- **CLASSIFY state:**
  - `cls_start` pulses in the first cycle only, and a timeout counter is cleared.
  - Events are accepted again, with the same rule as ACCUM.
  - `cls_done` → ACCUM.
  - Timeout counter reaching CLS_TIMEOUT → ACCUM with `timeout_count+1`.
  - `cls_done` arriving in the same cycle as the timeout counts as done, not a timeout.
  - ACCUM is entered only when no op is pending; otherwise the FSM waits for the op to complete.
- **Tick outside ACCUM:** in DECAY or CLASSIFY the tick is dropped, `overrun_count+1`, and `tick_pend` is not set.
- **Event priority:** events are never dropped. Backpressure only.

## Timing
- **Reset values:**
  - State ACCUM, timer 0.
  - Outputs: `evt_ready=1`, `map_op_valid=0`, `map_op_kind=0`, `map_op_addr=0`, `cls_start=0`, `frame_tick=0`, `busy=0`.
  - All counters 0, `tick_pend=0`.
- **Reset mid-operation:** an in-flight op is abandoned. `map_op_valid` is 0 in the cycle after `rst` is sampled.
- **Latency:**
  - Event accept to `map_op_valid`: 1 cycle.
  - Back-to-back events at 1/cycle while `map_op_ready=1`.
- **`frame_tick`:** first pulse in cycle FRAME_CYCLES-1 after reset release, then every FRAME_CYCLES cycles.
- **Sweep length:** with `map_op_ready` held high, the sweep takes exactly MAP_DEPTH cycles of `map_op_valid`. `cls_start` pulses 1 cycle after the last decay handshake.
- **`busy`:** registered. High from the first DECAY cycle through the last CLASSIFY cycle.
- **Stability:** `map_op_addr` and `map_op_kind` must not change while `map_op_valid && !map_op_ready`.

## Test plan
All scenarios use `CLK_FREQ_HZ=100_000`, `FRAME_PERIOD_MS=1` (FRAME_CYCLES=100), `MAP_DEPTH=16`, `CLS_TIMEOUT=20`.
- **Reset:** release `rst`, idle inputs → all outputs at reset values; first `frame_tick` at cycle 99; `frame_count=1`; decay addresses 0..15 in order; `cls_start` once; with `cls_done` returned 3 cycles later → back in ACCUM.
- **Event streaming:** events at addr 5,6,7 on consecutive cycles with `map_op_ready=1` → three `kind=0` ops on consecutive cycles with matching addresses, no stall.
- **Backpressure:** hold `map_op_ready=0` for 4 cycles with an op pending → `evt_ready=0`; op stable; accepted on the 5th cycle.
- **Tick with stalled op:** tick arrives while an event op is stalled → DECAY begins only after that op's handshake; no event accepted in between.
- **Classifier timeout:** `cls_done` never asserted → return to ACCUM 20 cycles after `cls_start`; `timeout_count=1`.
- **Overrun:** hold `map_op_ready=0` through a tick during DECAY → `overrun_count=1`; no extra sweep; `frame_count` unchanged until the next tick taken in ACCUM.
